// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: fetch state encoding, word size, R15 offset.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH      = 2'd1,
    VALID      = 2'd2
  } fetch_state_e;

  localparam int unsigned WORD_BYTES       = 4;
  localparam int unsigned PC_R15_OFFSET    = 8;
  localparam int unsigned TIMER_W          = 8;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_timer.sv
// Saturating wait-cycle counter for the fetch request; flags the cycle its count reaches TIMEOUT.
module fetch_timer
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_c
);

  localparam int unsigned          CNT_W   = TIMER_W + 1;
  localparam logic [TIMER_W-1:0]   CNT_MAX = '1;

  logic [TIMER_W-1:0] count_q;
  logic [CNT_W-1:0]   count_inc;

  // Extra bit keeps the compare correct once the counter is saturated.
  assign count_inc = {1'b0, count_q} + CNT_W'(1);
  assign hit_c     = en_i && (count_inc >= CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != CNT_MAX)) begin
      count_q <= count_inc[TIMER_W-1:0];
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC, requests words from imem, holds Instr for the controller/datapath.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] Result,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus8,
  output logic        fetch_err
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         req_q;
  logic         valid_q;
  logic         err_q;

  logic         in_fetch_c;
  logic         timer_hit_c;
  logic [31:0]  redirect_c;
  logic [31:0]  pc_seq_d;

  assign in_fetch_c = (state_q == FETCH);
  assign redirect_c = Result & ~32'h0000_0003;
  assign pc_seq_d   = pc_q + 32'(WORD_BYTES);

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (in_fetch_c && imem_ready),
    .en_i  (in_fetch_c && !imem_ready),
    .hit_c (timer_hit_c)
  );

  // Fetch FSM; stall in VALID takes priority over a pending redirect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (timer_hit_c) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        FETCH_IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= VALID;
          end
        end
        VALID: begin
          if (!stall) begin
            pc_q    <= PCSrc ? redirect_c : pc_seq_d;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= FETCH;
          end
        end
        default: begin
          state_q <= FETCH_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign Instr      = instr_q;
  assign InstrValid = valid_q;
  assign PC         = pc_q;
  assign PCPlus8    = pc_q + 32'(PC_R15_OFFSET);
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected {PC, Instr} queued at each handshake, checked on capture.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned TMO    = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        PCSrc;
  logic [31:0] Result;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus8;
  logic        fetch_err;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  fetch_unit #(
    .RESET_PC (RST_PC),
    .TIMEOUT  (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .PCSrc      (PCSrc),
    .Result     (Result),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .PC         (PC),
    .PCPlus8    (PCPlus8),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one fetch with the given wait states; ends one cycle after capture (DUT in VALID).
  task automatic do_fetch(input logic [31:0] word, input int waits, input logic [31:0] addr);
    exp_t e;
    for (int i = 0; i < waits; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== addr) begin
        errors++;
        $display("FAIL fetch_wait[%0d]: req=%b addr=%h, want req=1 addr=%h", i, imem_req, imem_addr, addr);
      end
      step();
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== addr) begin
      errors++;
      $display("FAIL fetch_hs: req=%b addr=%h, want req=1 addr=%h", imem_req, imem_addr, addr);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    e.pc    = addr;
    e.instr = word;
    sb.push_back(e);
    step();
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: no expected entry for capture");
    end else begin
      e = sb.pop_front();
      if (InstrValid !== 1'b1 || Instr !== e.instr || PC !== e.pc || PCPlus8 !== e.pc + 32'd8) begin
        errors++;
        $display("FAIL capture: valid=%b instr=%h pc=%h pc8=%h, want valid=1 instr=%h pc=%h pc8=%h",
                 InstrValid, Instr, PC, PCPlus8, e.instr, e.pc, e.pc + 32'd8);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; PCSrc = 1'b0; Result = 32'h0;
    step(); step();
    checks++;
    if (imem_req !== 1'b0 || InstrValid !== 1'b0 || Instr !== 32'h0 || fetch_err !== 1'b0 || PC !== RST_PC) begin
      errors++;
      $display("FAIL reset_state: req=%b valid=%b instr=%h err=%b pc=%h, want 0/0/0/0/%h",
               imem_req, InstrValid, Instr, fetch_err, PC, RST_PC);
    end
    reset = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      errors++;
      $display("FAIL reset_first_req: req=%b addr=%h, want req=1 addr=%h", imem_req, imem_addr, RST_PC);
    end
  endtask

  task automatic test_zero_wait();
    do_fetch(32'hE3A0_0001, 0, 32'h0);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL zw_valid_noreq: req=%b, want 0", imem_req);
    end
    step();
    checks++;
    if (imem_addr !== 32'h4 || imem_req !== 1'b1 || InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL zw_next_addr: addr=%h req=%b valid=%b, want 00000004/1/0", imem_addr, imem_req, InstrValid);
    end
  endtask

  task automatic test_wait_states();
    do_fetch(32'hE281_1001, 3, 32'h4);
    checks++;
    if (fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL ws_no_err: fetch_err=%b, want 0", fetch_err);
    end
    step();
    checks++;
    if (InstrValid !== 1'b0 || imem_addr !== 32'h8 || sb.size() != 0) begin
      errors++;
      $display("FAIL ws_single_capture: valid=%b addr=%h sb=%0d, want 0/00000008/0", InstrValid, imem_addr, sb.size());
    end
  endtask

  task automatic test_redirect();
    do_fetch(32'hEA00_0040, 1, 32'h8);
    PCSrc = 1'b1; Result = 32'h0000_0103;
    step();
    PCSrc = 1'b0; Result = 32'h0;
    checks++;
    if (imem_addr !== 32'h100 || InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL redir_addr: addr=%h valid=%b, want 00000100/0", imem_addr, InstrValid);
    end
    do_fetch(32'hE1A0_0000, 0, 32'h100);
    step();
  endtask

  task automatic test_stall();
    do_fetch(32'hE591_2000, 0, 32'h104);
    stall = 1'b1; PCSrc = 1'b1; Result = 32'h0000_0200;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (Instr !== 32'hE591_2000 || PC !== 32'h104 || InstrValid !== 1'b1 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: instr=%h pc=%h valid=%b req=%b, want e5912000/00000104/1/0",
                 i, Instr, PC, InstrValid, imem_req);
      end
    end
    stall = 1'b0;
    step();
    PCSrc = 1'b0; Result = 32'h0;
    checks++;
    if (imem_addr !== 32'h200 || imem_req !== 1'b1 || InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL stall_redir: addr=%h req=%b valid=%b, want 00000200/1/0", imem_addr, imem_req, InstrValid);
    end
  endtask

  task automatic test_wrap_and_timeout();
    exp_t e;
    do_fetch(32'hE12F_FF1E, 0, 32'h200);
    PCSrc = 1'b1; Result = 32'hFFFF_FFFF;
    step();
    PCSrc = 1'b0; Result = 32'h0;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_redir: addr=%h, want fffffffc", imem_addr);
    end
    do_fetch(32'hE320_F000, 0, 32'hFFFF_FFFC);
    step();
    checks++;
    if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL wrap_inc: addr=%h req=%b, want 00000000/1", imem_addr, imem_req);
    end
    for (int i = 1; i <= int'(TMO); i++) begin
      step();
      checks++;
      if (fetch_err !== (i >= int'(TMO)) || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
        errors++;
        $display("FAIL timeout_wait[%0d]: err=%b req=%b addr=%h, want err=%0d req=1 addr=00000000",
                 i, fetch_err, imem_req, imem_addr, (i >= int'(TMO)));
      end
    end
    imem_ready = 1'b1; imem_rdata = 32'hE3A0_2005;
    e.pc = 32'h0; e.instr = 32'hE3A0_2005;
    sb.push_back(e);
    step();
    imem_ready = 1'b0; imem_rdata = 32'h0;
    checks++;
    e = sb.pop_front();
    if (InstrValid !== 1'b1 || Instr !== e.instr || PC !== e.pc || fetch_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_complete: valid=%b instr=%h pc=%h err=%b, want 1/%h/%h/1",
               InstrValid, Instr, PC, fetch_err, e.instr, e.pc);
    end
    step();
    checks++;
    if (fetch_err !== 1'b1 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL timeout_sticky: err=%b addr=%h, want 1/00000004", fetch_err, imem_addr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    step();
    reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ready = 1'b0; imem_rdata = 32'h0;
    checks++;
    if (InstrValid !== 1'b0 || imem_req !== 1'b0 || PC !== RST_PC || Instr !== 32'h0 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b req=%b pc=%h instr=%h err=%b, want 0/0/%h/0/0",
               InstrValid, imem_req, PC, Instr, fetch_err, RST_PC);
    end
    reset = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC || sb.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_restart: req=%b addr=%h sb=%0d, want 1/%h/0", imem_req, imem_addr, sb.size(), RST_PC);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_redirect();
    test_stall();
    test_wrap_and_timeout();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the controller/datapath pair.
- Owns the PC register and issues one request per instruction to instruction memory over a req/ready handshake.
- Holds the returned word in an instruction register that drives the controller's Instr input and the datapath.
- Applies branch/PC-write redirects (PCSrc with Result) and supports a downstream stall and a fetch-timeout error flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
TIMEOUT, 255, maximum cycles FETCH waits for imem_ready before fetch_err is set (1..255)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset (asserted when 0)
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  word-aligned fetch address; always equals PC
imem_ready  in  1  memory has imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
stall  in  1  downstream cannot consume the current instruction
PCSrc  in  1  redirect request from the controller
Result  in  32  redirect target from the datapath
Instr  out  32  held instruction to the controller/datapath
InstrValid  out  1  Instr is valid; the controller gates RegWrite/MemWrite/PCSrc with it
PC  out  32  address of Instr
PCPlus8  out  32  PC+8, the ARM R15 read value
fetch_err  out  1  sticky timeout flag

Behaviour:
- Reset (reset==0 at a clk edge, in any state, including mid-request):
  - state=FETCH_IDLE; PC=RESET_PC.
  - imem_req=0, Instr=0, InstrValid=0, fetch_err=0, timer=0.
  - An outstanding request is abandoned; any imem_ready arriving while reset==0 is ignored.
- States:
  - FETCH_IDLE: imem_req=0. Goes to FETCH on the first edge with reset==1.
  - FETCH: imem_req=1 and imem_addr=PC, both held stable until imem_ready.
    - On imem_req&imem_ready: Instr<=imem_rdata, InstrValid<=1, timer<=0, go to VALID.
    - Zero-wait memory is legal (ready in the first FETCH cycle).
  - VALID: imem_req=0; Instr and PC held.
    - If stall==1: remain in VALID; all outputs unchanged.
    - If stall==0 and PCSrc==1: PC<={Result[31:2],2'b00}, InstrValid<=0, go to FETCH.
    - If stall==0 and PCSrc==0: PC<=PC+4, InstrValid<=0, go to FETCH.
- PCSrc is sampled only in VALID with stall==0; it is ignored in FETCH_IDLE and FETCH.
- Latency and throughput:
  - Minimum 2 cycles per instruction: one FETCH cycle plus one VALID cycle.
  - Instr is visible the cycle after the handshake.
- Arithmetic:
  - PC+4 and PC+8 are modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000).
  - PCPlus8 is combinational from PC.
  - Result bits [1:0] are discarded.
- Timeout:
  - timer increments each FETCH cycle without imem_ready.
  - When timer reaches TIMEOUT, fetch_err<=1 (sticky until reset). The request stays asserted; FETCH is not exited.
  - A later imem_ready still completes normally. The timer saturates and does not wrap.
- Simultaneous events: if stall==1 and PCSrc==1 in VALID, stall wins; PCSrc is re-sampled in the next unstalled VALID cycle.

Decomposition:
- Shared package (cpu_pkg):
  - fetch state enum (FETCH_IDLE, FETCH, VALID), 2-bit encoding
  - constant WORD_BYTES=4
  - constant PC_R15_OFFSET=8
  - default RESET_PC
- One sub-module, fetch_timer: saturating 8-bit counter with clear, enable and a compare-to-TIMEOUT output. PC/next-PC logic stays inline.

Test Plan:
- Reset then zero-wait memory returning 0xE3A0_0001 at addr 0 → imem_req high in cycle 1; Instr=0xE3A0_0001, InstrValid=1, PC=0, PCPlus8=8 in cycle 2; next imem_addr=4.
- Memory ready after 3 wait cycles → imem_addr stays constant for all 4 FETCH cycles; single capture; fetch_err stays 0.
- VALID with PCSrc=1, Result=0x0000_0103 → next imem_addr=0x0000_0100; PC=0x100 when the new Instr is valid.
- stall=1 for 5 cycles in VALID with PCSrc=1 → Instr/PC/InstrValid frozen and no request; the redirect is taken on the first stall=0 cycle.
- PC=0xFFFF_FFFC, no redirect → next imem_addr=0x0000_0000. Separately, imem_ready held low for TIMEOUT=4 cycles → fetch_err=1 and stays 1 after a later completion.
- reset=0 asserted mid-FETCH with imem_ready arriving the same cycle → no capture; InstrValid=0, PC=RESET_PC, imem_req=0 next cycle.
